// File: rtl/ram_port_arbiter.sv
// Two-master round-robin arbiter in front of a single-port 32-bit RAM.
// Grants are combinational. Each granted access receives exactly one
// response in the following cycle. Illegal byte-enable patterns and
// out-of-range addresses are granted, but they never reach the RAM and
// they answer with an error.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 22
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req_i,
    input  logic [31:0]           m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_be_i,
    input  logic [31:0]           m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [31:0]           m0_rdata_o,
    output logic                  m0_err_o,
    input  logic                  m1_req_i,
    input  logic [31:0]           m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_be_i,
    input  logic [31:0]           m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [31:0]           m1_rdata_o,
    output logic                  m1_err_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    // Only naturally aligned byte, halfword and word accesses are accepted.
    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            4'b1111, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b1100: be_legal = 1'b1;
            default:                   be_legal = 1'b0;
        endcase
    endfunction

    // The RAM expects the byte address of the lowest enabled lane.
    function automatic logic [1:0] be_offset(input logic [3:0] be);
        case (be)
            4'b0010:          be_offset = 2'd1;
            4'b0100, 4'b1100: be_offset = 2'd2;
            4'b1000:          be_offset = 2'd3;
            default:          be_offset = 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    logic        rr_q;
    logic        gnt0, gnt1, any_gnt, sel_id, sel_legal;
    logic [31:0] sel_addr, sel_wdata;
    logic [3:0]  sel_be;
    logic        sel_we;

    logic        vld_p1, id_p1, we_p1, err_p1;
    logic [3:0]  be_p1;
    logic        rsp_live;
    logic [31:0] rsp_data;

    // Arbitration, request mux and RAM port drive (all combinational).
    always_comb begin
        gnt0      = rst_n & m0_req_i & (~m1_req_i | ~rr_q);
        gnt1      = rst_n & m1_req_i & (~m0_req_i | rr_q);
        any_gnt   = gnt0 | gnt1;
        sel_id    = gnt1;
        sel_addr  = gnt1 ? m1_addr_i  : m0_addr_i;
        sel_we    = gnt1 ? m1_we_i    : m0_we_i;
        sel_be    = gnt1 ? m1_be_i    : m0_be_i;
        sel_wdata = gnt1 ? m1_wdata_i : m0_wdata_i;
        sel_legal = be_legal(sel_be) && ((sel_addr >> ADDR_WIDTH) == 32'd0);

        ram_en_o    = 1'b0;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'b0;
        ram_wdata_o = 32'd0;
        if (any_gnt && sel_legal) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = {sel_addr[ADDR_WIDTH-1:2], be_offset(sel_be)};
            ram_we_o    = sel_we;
            ram_be_o    = sel_be;
            ram_wdata_o = sel_wdata;
        end
    end

    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    // ---- stage p1: response registers ----
    // Control state: round-robin pointer and response valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q   <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= any_gnt;
            if (any_gnt) rr_q <= ~sel_id;
        end
    end

    // Response attributes captured for the access granted this cycle.
    always_ff @(posedge clk) begin
        if (any_gnt) begin
            id_p1  <= sel_id;
            we_p1  <= sel_we;
            be_p1  <= sel_be;
            err_p1 <= ~sel_legal;
        end
    end

    // Response routing. A response still pending while rst_n is low is discarded.
    always_comb begin
        rsp_live    = vld_p1 & rst_n;
        rsp_data    = (~we_p1 & ~err_p1) ? (ram_rdata_i & lane_mask(be_p1)) : 32'd0;
        m0_rvalid_o = rsp_live & ~id_p1;
        m1_rvalid_o = rsp_live & id_p1;
        m0_rdata_o  = m0_rvalid_o ? rsp_data : 32'd0;
        m1_rdata_o  = m1_rvalid_o ? rsp_data : 32'd0;
        m0_err_o    = m0_rvalid_o & err_p1;
        m1_err_o    = m1_rvalid_o & err_p1;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter. The bench keeps a
// transaction-level reference model (preferred master, pending response
// and a word memory). It also contains a behavioural RAM that answers
// the DUT's RAM port.
module tb_ram_port_arbiter;
    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0]   m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic [3:0]    m0_be_i, m1_be_i;
    logic          m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0]   m0_rdata_o, m1_rdata_o;
    logic          ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [3:0]    ram_be_o;
    logic [31:0]   ram_wdata_o;
    logic [31:0]   ram_rdata_i = 32'd0;

    ram_port_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
        .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
        .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
        .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: word array. Unread cycles return noise on rdata.
    logic [31:0] tram [int];
    always @(posedge clk) begin
        if (ram_en_o && ram_we_o) begin
            for (int i = 0; i < 4; i++)
                if (ram_be_o[i]) begin
                    if (!tram.exists(int'(ram_addr_o >> 2))) tram[int'(ram_addr_o >> 2)] = 32'd0;
                    tram[int'(ram_addr_o >> 2)][8*i +: 8] = ram_wdata_o[8*i +: 8];
                end
            ram_rdata_i <= $urandom;
        end else if (ram_en_o) begin
            ram_rdata_i <= tram.exists(int'(ram_addr_o >> 2)) ? tram[int'(ram_addr_o >> 2)] : 32'd0;
        end else begin
            ram_rdata_i <= $urandom;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          pref = 0;
    bit          pend_v = 0;
    int          pend_id = 0;
    bit          pend_err = 0;
    logic [31:0] pend_rdata = 32'd0;
    logic [31:0] mmem [int];

    function automatic int low_lane(input logic [3:0] be);
        for (int i = 0; i < 4; i++) if (be[i]) return i;
        return 0;
    endfunction

    // An access is legal when it covers 1, 2 or 4 bytes and is size-aligned.
    function automatic bit model_legal(input logic [31:0] a, input logic [3:0] be);
        int n, lo;
        bit ok;
        n  = $countones(be);
        lo = low_lane(be);
        ok = (n == 1) || (n == 4) ||
             (n == 2 && (lo % 2 == 0) && be == (4'b0011 << lo));
        return ok && (a >> AW) == 32'd0;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // One clock cycle: check outputs mid-cycle against the model, then advance it.
    task automatic step();
        int          gid, word;
        logic [31:0] a, wd, ea, mw;
        logic [3:0]  be;
        bit          we, legal, ev0, ev1;
        @(negedge clk);
        ev0 = rst_n && pend_v && pend_id == 0;
        ev1 = rst_n && pend_v && pend_id == 1;
        chk("rvalid0", 32'(m0_rvalid_o), 32'(ev0));
        chk("rvalid1", 32'(m1_rvalid_o), 32'(ev1));
        chk("rdata0", m0_rdata_o, ev0 ? pend_rdata : 32'd0);
        chk("rdata1", m1_rdata_o, ev1 ? pend_rdata : 32'd0);
        chk("err0", 32'(m0_err_o), 32'(ev0 && pend_err));
        chk("err1", 32'(m1_err_o), 32'(ev1 && pend_err));

        gid = -1;
        if (rst_n) begin
            if (m0_req_i && m1_req_i) gid = pref;
            else if (m0_req_i)        gid = 0;
            else if (m1_req_i)        gid = 1;
        end
        chk("gnt0", 32'(m0_gnt_o), 32'(gid == 0));
        chk("gnt1", 32'(m1_gnt_o), 32'(gid == 1));

        a  = (gid == 1) ? m1_addr_i  : m0_addr_i;
        we = (gid == 1) ? m1_we_i    : m0_we_i;
        be = (gid == 1) ? m1_be_i    : m0_be_i;
        wd = (gid == 1) ? m1_wdata_i : m0_wdata_i;
        legal = model_legal(a, be);
        chk("ram_en", 32'(ram_en_o), 32'(gid >= 0 && legal));
        if (gid < 0 || legal) begin
            ea = (gid < 0) ? 32'd0 : (((a % (32'd1 << AW)) / 4) * 4 + 32'(low_lane(be)));
            chk("ram_addr", 32'(ram_addr_o), ea);
            chk("ram_we", 32'(ram_we_o), 32'(gid >= 0 && we));
            chk("ram_be", 32'(ram_be_o), (gid < 0) ? 32'd0 : 32'(be));
            chk("ram_wdata", ram_wdata_o, (gid < 0) ? 32'd0 : wd);
        end

        if (!rst_n) begin
            pref   = 0;
            pend_v = 0;
        end else begin
            pend_v = (gid >= 0);
            if (gid >= 0) begin
                word       = int'((a % (32'd1 << AW)) / 4);
                mw         = mmem.exists(word) ? mmem[word] : 32'd0;
                pend_id    = gid;
                pend_err   = !legal;
                pend_rdata = (legal && !we) ? (mw & byte_mask(be)) : 32'd0;
                if (legal && we) mmem[word] = (mw & ~byte_mask(be)) | (wd & byte_mask(be));
                pref       = 1 - gid;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req_i = 0; m0_addr_i = 0; m0_we_i = 0; m0_be_i = 0; m0_wdata_i = 0;
        m1_req_i = 0; m1_addr_i = 0; m1_we_i = 0; m1_be_i = 0; m1_wdata_i = 0;
    endtask

    logic [3:0] legal_be [7] = '{4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100};

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        if ($urandom_range(0, 9) == 0) a[$urandom_range(AW, 31)] = 1'b1;
        return a;
    endfunction

    function automatic logic [3:0] rnd_be();
        if ($urandom_range(0, 3) == 0) return 4'($urandom);
        return legal_be[$urandom_range(0, 6)];
    endfunction

    initial begin
        // Reset with both masters requesting: nothing may be granted.
        idle();
        rst_n = 0;
        m0_req_i = 1; m1_req_i = 1; m0_be_i = 4'hF; m1_be_i = 4'hF;
        step(); step();
        rst_n = 1;
        idle();
        step();

        // Both masters read for 4 cycles: grants alternate starting at m0.
        m0_req_i = 1; m0_be_i = 4'hF; m0_addr_i = 32'h10;
        m1_req_i = 1; m1_be_i = 4'hF; m1_addr_i = 32'h20;
        repeat (4) step();
        idle(); step();

        // Byte write to lane 3 then read back.
        m0_req_i = 1; m0_we_i = 1; m0_be_i = 4'b1000; m0_addr_i = 32'h104; m0_wdata_i = 32'hAB000000;
        step();
        chk("b2b_wr_addr_seen", 32'(pend_v), 32'd1);
        m0_we_i = 0; m0_wdata_i = 32'h0;
        step();
        idle(); step();

        // Illegal byte enable from m1, then out-of-range address from m0.
        m1_req_i = 1; m1_be_i = 4'b0110; m1_addr_i = 32'h8;
        step();
        idle();
        m0_req_i = 1; m0_be_i = 4'hF; m0_addr_i = 32'h0040_0000; m0_we_i = 1; m0_wdata_i = 32'h12345678;
        step();
        idle(); step();

        // m0 alone for three cycles.
        m0_req_i = 1; m0_be_i = 4'hF; m0_addr_i = 32'h104;
        repeat (3) step();
        idle(); step();

        // Read granted, reset in the next cycle: the response is dropped.
        m1_req_i = 1; m1_be_i = 4'hF; m1_addr_i = 32'h104;
        step();
        idle(); rst_n = 0;
        step();
        rst_n = 1;
        m0_req_i = 1; m1_req_i = 1; m0_be_i = 4'hF; m1_be_i = 4'hF;
        step();
        idle(); step();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 49) != 0);
            m0_req_i   = ($urandom_range(0, 9) < 6);
            m0_we_i    = $urandom_range(0, 1) == 1;
            m0_addr_i  = rnd_addr();
            m0_be_i    = rnd_be();
            m0_wdata_i = $urandom;
            m1_req_i   = ($urandom_range(0, 9) < 6);
            m1_we_i    = $urandom_range(0, 1) == 1;
            m1_addr_i  = rnd_addr();
            m1_be_i    = rnd_be();
            m1_wdata_i = $urandom;
            step();
        end
        rst_n = 1;
        idle();
        step(); step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
